// File: rtl/hadamard_mul.sv
`default_nettype none
// ============================================================================
// Module   : hadamard_mul
// Purpose  : y = H*u with H the NxN Sylvester Walsh-Hadamard matrix, computed
//            as an iterative fast WHT (one butterfly stage per clock).
// Revision : 1.0  initial release
// ============================================================================
module hadamard_mul #(
    parameter int M    = 8,
    parameter int N    = 16,
    parameter int LOGN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid,
    input  logic [M*N-1:0]          u,
    output logic                    ready,
    output logic [N*(M+LOGN)-1:0]   y
);

    localparam int c_W  = M + LOGN;
    localparam int c_SW = (LOGN > 1) ? $clog2(LOGN) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [c_SW-1:0]         r_stage;
    logic signed [c_W-1:0]   r_work [N];
    logic [N*c_W-1:0]        r_y;
    logic                    r_ready;

    logic signed [c_W-1:0]   w_load  [N];
    logic signed [c_W-1:0]   w_stage [LOGN][N];
    logic signed [c_W-1:0]   w_next  [N];
    logic [N*c_W-1:0]        w_next_flat;

    genvar k, s, a;

    generate
        for (k = 0; k < N; k++) begin : g_load
            assign w_load[k] = {{LOGN{u[k*M+M-1]}}, u[k*M +: M]};
        end
    endgenerate

    // Every stage's butterfly network is built; the stage counter picks one.
    generate
        for (s = 0; s < LOGN; s++) begin : g_stage
            for (a = 0; a < N; a++) begin : g_bfly
                if (((a >> s) & 1) == 0) begin : g_lo
                    assign w_stage[s][a] = r_work[a] + r_work[a + (1 << s)];
                end else begin : g_hi
                    assign w_stage[s][a] = r_work[a - (1 << s)] - r_work[a];
                end
            end
        end
    endgenerate

    always_comb begin
        w_next = w_stage[0];
        for (int i = 0; i < LOGN; i++) begin
            if (int'(r_stage) == i) begin
                w_next = w_stage[i];
            end
        end
    end

    generate
        for (k = 0; k < N; k++) begin : g_flat
            assign w_next_flat[k*c_W +: c_W] = w_next[k];
        end
    endgenerate

    // y is only written at the end of the final stage, so it stays stable during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_stage <= '0;
            r_y     <= '0;
            r_ready <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_work[i] <= '0;
            end
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid) begin
                        r_work  <= w_load;
                        r_stage <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_work <= w_next;
                    if (int'(r_stage) == LOGN - 1) begin
                        r_y     <= w_next_flat;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_stage <= r_stage + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready = r_ready;
    assign y     = r_y;

endmodule
`default_nettype wire

// File: tb/tb_hadamard_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_hadamard_mul
// Purpose  : Scoreboard bench for hadamard_mul against a direct-sum WHT model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hadamard_mul;

    localparam int M    = 8;
    localparam int N    = 16;
    localparam int LOGN = 4;
    localparam int W    = M + LOGN;
    localparam int TW   = N * W;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid = 1'b0;
    logic [M*N-1:0]  u     = '0;
    logic            ready;
    logic [TW-1:0]   y;

    hadamard_mul #(.M(M), .N(N), .LOGN(LOGN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid),
        .u     (u),
        .ready (ready),
        .y     (y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TW-1:0] exp;
        int            due;
    } item_t;

    item_t sb[$];
    item_t mon_it;
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // y_i = sum_j (-1)^popcount(i&j) * u_j, evaluated directly.
    function automatic logic [TW-1:0] model(input logic [M*N-1:0] v);
        logic [TW-1:0]      res;
        logic signed [M-1:0] e;
        int                 acc;
        res = '0;
        for (int i = 0; i < N; i++) begin
            acc = 0;
            for (int j = 0; j < N; j++) begin
                e = v[j*M +: M];
                if (($countones(i & j) % 2) == 1) acc = acc - int'(e);
                else                              acc = acc + int'(e);
            end
            res[i*W +: W] = acc[W-1:0];
        end
        return res;
    endfunction

    function automatic logic [M*N-1:0] rand_vec();
        logic [M*N-1:0] v;
        for (int i = 0; i < N; i++) v[i*M +: M] = M'($urandom);
        return v;
    endfunction

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_ready", TW'(1), TW'(0));
            end else begin
                mon_it = sb.pop_front();
                chk("y", y, mon_it.exp);
                chk("latency", TW'(cyc), TW'(mon_it.due));
            end
        end
    end

    // Drives one accepted vector and returns on the negedge before the ready cycle.
    task automatic send(input logic [M*N-1:0] v);
        item_t it;
        @(negedge clk);
        valid  = 1'b1;
        u      = v;
        it.exp = model(v);
        it.due = cyc + LOGN + 1;
        sb.push_back(it);
        @(negedge clk);
        valid = 1'b0;
        u     = rand_vec();
        repeat (LOGN - 1) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [M*N-1:0] v;
        int             wait_cnt;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", TW'(ready), TW'(0));
        chk("rst_y", y, '0);
        rst_n = 1'b1;
        @(negedge clk);

        send('0);
        v = '0; v[0 +: M] = 8'h01;  send(v);
        send({N{8'h01}});
        send({N{8'h80}});
        send({N{8'h7F}});
        v = '0; v[5*M +: M] = 8'd127; send(v);
        repeat (2) @(negedge clk);

        // valid re-pulsed during RUN must not disturb the first vector
        @(negedge clk);
        v = rand_vec();
        valid = 1'b1; u = v;
        mon_it.exp = model(v); mon_it.due = cyc + LOGN + 1;
        sb.push_back(mon_it);
        @(negedge clk);
        u = rand_vec();
        @(negedge clk);
        valid = 1'b0;
        repeat (LOGN + 2) @(negedge clk);

        // reset asserted while stage 2 is pending aborts the computation
        valid = 1'b1; u = rand_vec();
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", TW'(ready), TW'(0));
        @(negedge clk);
        chk("abort_y", y, '0);
        rst_n = 1'b1;
        repeat (LOGN + 3) @(negedge clk);
        chk("post_abort_ready", TW'(ready), TW'(0));
        chk("post_abort_y", y, '0);

        send(rand_vec());
        for (int n = 0; n < 100; n++) send(rand_vec());

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("drain", TW'(sb.size()), TW'(0));
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
